// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the fetch / decode boundary:
//   - default address and instruction widths, reset PC and the NOP pattern
//   - fetch_entry_t : one queued fetch {pc, pc_plus1, instr}
//   - count_state_e : occupancy of the 2-entry skid buffer
//   - make_entry    : builds an entry from a fetch address and its instruction
// ----------------------------------------------------------------------------
package if_pkg;

  localparam int IF_ADDR_W  = 32;
  localparam int IF_INSTR_W = 32;

  localparam logic [IF_ADDR_W-1:0]  IF_RESET_PC  = 32'd0;
  localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 32'd0;

  typedef struct packed {
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_ADDR_W-1:0]  pc_plus1;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_state_e;

  // Word-addressed PC: the sequential successor is +1, wrapping modulo 2^ADDR_W.
  function automatic fetch_entry_t make_entry(
    input logic [IF_ADDR_W-1:0]  fetch_pc,
    input logic [IF_INSTR_W-1:0] fetch_instr
  );
    fetch_entry_t e;
    e.pc       = fetch_pc;
    e.pc_plus1 = fetch_pc + IF_ADDR_W'(1);
    e.instr    = fetch_instr;
    return e;
  endfunction

endpackage

// File: rtl/if_id_skid_fifo.sv
// ----------------------------------------------------------------------------
// if_id_skid_fifo
// Two-entry register FIFO between fetch and decode. The head slot is a
// register that drives decode directly; an empty head is parked at an
// all-zero address with NOP_INSTR so decode outputs stay registered.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           drop every entry (wins over push/pop)
//   push/push_entry enqueue one fetch entry
//   pop             dequeue the head (ignored when empty)
//   head_entry      registered head slot
//   valid           registered "head holds a real entry"
//   count           occupancy state EMPTY/ONE/FULL
// ----------------------------------------------------------------------------
module if_id_skid_fifo
  import if_pkg::*;
#(
  parameter logic [IF_INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic         valid,
  output count_state_e count
);

  localparam fetch_entry_t EMPTY_ENTRY = '{
    pc:       {IF_ADDR_W{1'b0}},
    pc_plus1: {IF_ADDR_W{1'b0}},
    instr:    NOP_INSTR
  };

  count_state_e state_r, state_nx_s;
  fetch_entry_t head_r, head_nx_s;
  fetch_entry_t tail_r, tail_nx_s;
  logic         valid_r;

  // State and slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
      head_r  <= EMPTY_ENTRY;
      tail_r  <= EMPTY_ENTRY;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      head_r  <= head_nx_s;
      tail_r  <= tail_nx_s;
      valid_r <= (state_nx_s != EMPTY);
    end
  end

  // Next occupancy and slot contents; the tail shifts into the head on pop.
  always_comb begin
    state_nx_s = state_r;
    head_nx_s  = head_r;
    tail_nx_s  = tail_r;
    if (clear) begin
      state_nx_s = EMPTY;
      head_nx_s  = EMPTY_ENTRY;
      tail_nx_s  = EMPTY_ENTRY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push) begin
            head_nx_s  = push_entry;
            state_nx_s = ONE;
          end else begin
            state_nx_s = EMPTY;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_nx_s  = push_entry;
            state_nx_s = ONE;
          end else if (push) begin
            tail_nx_s  = push_entry;
            state_nx_s = FULL;
          end else if (pop) begin
            head_nx_s  = EMPTY_ENTRY;
            state_nx_s = EMPTY;
          end else begin
            state_nx_s = ONE;
          end
        end
        FULL: begin
          if (pop) begin
            head_nx_s = tail_r;
            if (push) begin
              tail_nx_s  = push_entry;
              state_nx_s = FULL;
            end else begin
              tail_nx_s  = EMPTY_ENTRY;
              state_nx_s = ONE;
            end
          end else begin
            state_nx_s = FULL;
          end
        end
        default: begin
          state_nx_s = EMPTY;
          head_nx_s  = EMPTY_ENTRY;
          tail_nx_s  = EMPTY_ENTRY;
        end
      endcase
    end
  end

  assign head_entry = head_r;
  assign valid      = valid_r;
  assign count      = state_r;

endmodule

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Owns the architectural PC, drives it to the fetch stage, and queues fetched
// instructions toward decode through a 2-entry skid buffer with a
// valid/ready handshake and branch flush.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   pc              current fetch address
//   if_new_pc       next PC from fetch (pc+1 or branch target)
//   if_instruction  instruction at pc (same cycle)
//   flush           discard buffered entries and redirect pc to if_new_pc
//   id_valid/id_ready  decode handshake
//   id_instr, id_pc head instruction and its address + 1
//   bubble_cnt      (only with IF_ID_BUBBLE_CNT_EN) saturating count of cycles
//                   where decode was ready but nothing was valid
// Widths follow if_pkg; ADDR_W/INSTR_W must match IF_ADDR_W/IF_INSTR_W.
// ----------------------------------------------------------------------------
module if_id_buffer
  import if_pkg::*;
#(
  parameter int                  ADDR_W    = IF_ADDR_W,
  parameter int                  INSTR_W   = IF_INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC  = IF_RESET_PC,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = IF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  if_new_pc,
  input  logic [INSTR_W-1:0] if_instruction,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [31:0]        bubble_cnt
`endif
);

  logic [ADDR_W-1:0] pc_r, pc_nx_s;
  logic              pop_s;
  logic              fetch_fire_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      head_s;
  logic              head_valid_s;
  count_state_e      count_s;
  logic              unused_head_pc_s;

  assign pop_s        = head_valid_s & id_ready;
  // A full buffer can still accept a fetch when decode frees a slot this cycle.
  assign fetch_fire_s = ~flush & ((count_s != FULL) | pop_s);
  assign push_entry_s = make_entry(pc_r, if_instruction);

  // Next PC: redirect on flush, advance on a fired fetch, otherwise stall.
  always_comb begin
    pc_nx_s = pc_r;
    if (flush || fetch_fire_s) begin
      pc_nx_s = if_new_pc;
    end else begin
      pc_nx_s = pc_r;
    end
  end

  // Architectural PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_nx_s;
    end
  end

  if_id_skid_fifo #(
    .NOP_INSTR (NOP_INSTR)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .push       (fetch_fire_s),
    .pop        (pop_s),
    .push_entry (push_entry_s),
    .head_entry (head_s),
    .valid      (head_valid_s),
    .count      (count_s)
  );

  // The entry's own address is kept for trace visibility; decode sees pc+1.
  assign unused_head_pc_s = ^head_s.pc;

  assign pc       = pc_r;
  assign id_valid = head_valid_s;
  assign id_instr = head_s.instr;
  assign id_pc    = head_s.pc_plus1;

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_r;

  // Saturating bubble counter: decode ready with nothing to take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_r <= 32'd0;
    end else if (id_ready && !head_valid_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] if_new_pc;
  logic [31:0] if_instruction;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  logic        br_en;
  logic [31:0] br_target;
  int          checks;
  int          errors;

  // Instruction memory model: a recognisable pattern derived from the address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  assign if_instruction = instr_at(pc);
  assign if_new_pc      = br_en ? br_target : (pc + 32'd1);

  if_id_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .if_new_pc      (if_new_pc),
    .if_instruction (if_instruction),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    id_ready  = 1'b1;
    br_en     = 1'b0;
    br_target = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pc",    pc,       32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_idpc",  id_pc,    32'd0);
    rst = 1'b1;

    // Sequential fetch, decode always ready: entry k has id_pc k+1
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("seq_pc",    pc,       32'(k));
      chk("seq_valid", {31'd0, id_valid}, 32'd1);
      chk("seq_idpc",  id_pc,    32'(k));
      chk("seq_instr", id_instr, instr_at(32'(k - 1)));
    end

    // Back-pressure with instr@5 at the head for 4 cycles
    id_ready = 1'b0;
    step();
    chk("bp_pc_first", pc, 32'd7);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      chk("bp_pc_hold", pc,       32'd7);
      chk("bp_valid",   {31'd0, id_valid}, 32'd1);
      chk("bp_instr",   id_instr, instr_at(32'd5));
      chk("bp_idpc",    id_pc,    32'd6);
    end
    id_ready = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("rel_valid", {31'd0, id_valid}, 32'd1);
      chk("rel_instr", id_instr, instr_at(32'(k)));
      chk("rel_idpc",  id_pc,    32'(k + 1));
      chk("rel_pc",    pc,       32'(k + 2));
    end

    // Flush with a full buffer, redirect to 0x40
    id_ready  = 1'b0;
    flush     = 1'b1;
    br_en     = 1'b1;
    br_target = 32'h40;
    step();
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_pc",    pc,       32'h40);
    chk("fl_instr", id_instr, 32'd0);
    flush    = 1'b0;
    br_en    = 1'b0;
    id_ready = 1'b1;
    step();
    chk("fl_next_valid", {31'd0, id_valid}, 32'd1);
    chk("fl_next_idpc",  id_pc,    32'h41);
    chk("fl_next_instr", id_instr, instr_at(32'h40));

    // Flush together with pop while one entry is held
    flush     = 1'b1;
    br_en     = 1'b1;
    br_target = 32'h80;
    step();
    chk("flpop_valid", {31'd0, id_valid}, 32'd0);
    chk("flpop_pc",    pc, 32'h80);
    flush = 1'b0;
    br_en = 1'b0;
    step();
    chk("flpop_idpc",  id_pc,    32'h81);
    chk("flpop_instr", id_instr, instr_at(32'h80));

    // PC wrap: entry at all-ones reports id_pc 0
    flush     = 1'b1;
    br_en     = 1'b1;
    br_target = 32'hFFFF_FFFF;
    step();
    chk("wrap_pc", pc, 32'hFFFF_FFFF);
    flush = 1'b0;
    br_en = 1'b0;
    step();
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_idpc",  id_pc,    32'd0);
    chk("wrap_instr", id_instr, instr_at(32'hFFFF_FFFF));
    chk("wrap_pcnext", pc, 32'd0);

    // Fill up, then reset asynchronously between edges
    id_ready = 1'b0;
    step();
    step();
    chk("full_pc_hold", pc, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_pc",    pc,       32'd0);
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_idpc",  id_pc,    32'd0);
    chk("arst_instr", id_instr, 32'd0);

`ifdef IF_ID_BUBBLE_CNT_EN
    chk("bub_rst", bubble_cnt, 32'd0);
    id_ready = 1'b1;
    flush    = 1'b1;
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("bub_three", bubble_cnt, 32'd3);
    id_ready = 1'b0;
    repeat (2) step();
    chk("bub_hold", bubble_cnt, 32'd3);
    flush = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
